// File: rtl/macc_pkg.sv
// macc_pkg: op encoding, width limits and overflow range check shared by macc_pipe
package macc_pkg;
  typedef enum logic [1:0] {MUL, ACC, MACC_C, SUB} macc_op_t;
  localparam int AB_MIN_W = 2;
  localparam int AB_MAX_W = 32;
  localparam int Y_MAX_W = 64;
  function automatic logic macc_ovf(input logic [Y_MAX_W:0] s, input logic [6:0] w, input logic sgn);
    return sgn ? (s[w] != s[w - 7'd1]) : s[w];
  endfunction
endpackage

// File: rtl/macc_pipe_acc.sv
// macc_pipe_acc: stage-3 accumulator with overflow flag; MACC_PIPE_SAT_EN selects clamp instead of wrap
module macc_pipe_acc import macc_pkg::*; #(
  parameter int Y_WIDTH = 48,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               en,
  input  logic               p_valid,
  input  macc_op_t           op,
  input  logic [Y_WIDTH-1:0] p,
  input  logic [Y_WIDTH-1:0] c,
  output logic               y_valid,
  output logic [Y_WIDTH-1:0] y,
  output logic               ovf
);
  logic [Y_WIDTH:0] ye, pe, ce, s;
  logic [Y_MAX_W:0] sx;
  logic of;
  logic [Y_WIDTH-1:0] y_nxt;
  always_comb begin
    ye = {SIGNED & y[Y_WIDTH-1], y};
    pe = {SIGNED & p[Y_WIDTH-1], p};
    ce = {SIGNED & c[Y_WIDTH-1], c};
    s = op == MUL ? pe : op == ACC ? ye + pe : op == MACC_C ? ce + pe : ye - pe;
    sx = '0;
    sx[Y_WIDTH:0] = s;
    of = macc_ovf(sx, 7'(Y_WIDTH), SIGNED);
`ifdef MACC_PIPE_SAT_EN
    y_nxt = !of ? s[Y_WIDTH-1:0] :
            SIGNED ? {s[Y_WIDTH], {(Y_WIDTH-1){~s[Y_WIDTH]}}} : {Y_WIDTH{op != SUB}};
`else
    y_nxt = s[Y_WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      y_valid <= 1'b0;
      y <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      y_valid <= p_valid;
      if (p_valid) begin
        y <= y_nxt;
        ovf <= of | (ovf & (op == ACC || op == SUB));
      end
    end
endmodule

// File: rtl/macc_pipe.sv
// macc_pipe: 3-stage pipelined MACC (register, product, accumulator); optional MACC_PIPE_SAT_EN saturation
module macc_pipe import macc_pkg::*; #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 25,
  parameter int Y_WIDTH = 48,
  parameter bit SIGNED = 1'b1
) (
  input  logic               CLK,
  input  logic               ARST_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [1:0]         OP,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [Y_WIDTH-1:0] C,
  output logic               Y_VALID,
  input  logic               Y_READY,
  output logic [Y_WIDTH-1:0] Y,
  output logic               OVF
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int XW = PW > Y_WIDTH ? PW : Y_WIDTH;
  logic en, v1, v2;
  logic [A_WIDTH-1:0] a1;
  logic [B_WIDTH-1:0] b1;
  logic [Y_WIDTH-1:0] c1, c2, p2;
  logic [XW-1:0] ax, bx;
  macc_op_t op1, op2;
  assign en = !Y_VALID || Y_READY;
  assign IN_READY = en;
  // Extending both operands to XW makes the low Y_WIDTH bits of the product correct for either sign mode
  always_comb begin
    ax = {{(XW-A_WIDTH){SIGNED & a1[A_WIDTH-1]}}, a1};
    bx = {{(XW-B_WIDTH){SIGNED & b1[B_WIDTH-1]}}, b1};
  end
  always_ff @(posedge CLK or negedge ARST_N)
    if (!ARST_N) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (en) begin
      v1 <= IN_VALID;
      v2 <= v1;
    end
  always_ff @(posedge CLK)
    if (en) begin
      a1 <= A;
      b1 <= B;
      c1 <= C;
      op1 <= macc_op_t'(OP);
      p2 <= Y_WIDTH'(ax * bx);
      c2 <= c1;
      op2 <= op1;
    end
  macc_pipe_acc #(.Y_WIDTH(Y_WIDTH), .SIGNED(SIGNED)) u_acc (
    .clk(CLK), .arst_n(ARST_N), .en(en), .p_valid(v2), .op(op2), .p(p2), .c(c2),
    .y_valid(Y_VALID), .y(Y), .ovf(OVF)
  );
endmodule
